ram_arbiter: RTL
================

Name: ram_arbiter

Overview:
- Single-port RAM arbiter and sequencer between the instruction-fetch port and the data-memory port of the pipelined MIPS datapath.
- Grants one requester at a time, drives the shared RAM bus, and returns hit pulses and load data to the granted side.
- Data requests win ties, since the MEM-stage instruction is older than the fetch.
- A streak limit prevents instruction starvation; a timeout aborts hung accesses.

Parameters:
- MAX_DSTREAK, 4, max consecutive data grants while iREN is pending before instruction is forced.
- TIMEOUT, 16, cycles in an access state without ram_ready before abort; must be >=2.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  1  instruction read request.
- iaddr  in  32  instruction word address.
- ihit  out  1  instruction access complete (1-cycle pulse).
- iload  out  32  instruction data, valid when ihit.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  32  data address.
- dstore  in  32  data write value.
- dhit  out  1  data access complete (1-cycle pulse).
- dload  out  32  data read value, valid when dhit and read.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data, valid with ram_ready.
- ram_ready  in  1  RAM access complete this cycle.
- timeout  out  1  1-cycle pulse on an aborted access.

Behaviour:
- Clocking and reset: one clock CLK; nRST is asynchronous, active-low.
- Reset values: state=IDLE, dstreak=0, wait_cnt=0, all outputs 0.
- Reset mid-access drops ramREN/ramWEN immediately (asynchronous); no hit is issued.
- FSM states: IDLE, IACC, DACC. The state register and counters are the only sequential elements.
- IDLE: all ram* outputs 0 and ramaddr=0. Arbitration uses current inputs:
  - If (dREN|dWEN) and (!iREN or dstreak<MAX_DSTREAK): go to DACC. dstreak increments (saturating) if iREN=1, else clears.
  - Else if iREN: go to IACC and clear dstreak.
  - Else stay in IDLE.
- IACC:
  - Outputs: ramREN=1, ramaddr=iaddr (combinational pass-through), ramWEN=0.
  - iREN=0: return to IDLE with no ihit. Withdrawal wins over a simultaneous ram_ready.
  - ram_ready=1: ihit=1, iload=ramload in the same cycle; go to IDLE.
- DACC:
  - If dWEN=1: ramWEN=1, ramstore=dstore, ramREN=0.
  - If dWEN=0 and dREN=1: ramREN=1.
  - If dREN and dWEN are both 1, the write wins.
  - ramaddr=daddr.
  - ram_ready=1: dhit=1; dload=ramload for reads and 0 for writes; go to IDLE.
  - dREN=dWEN=0: return to IDLE with no hit.
- Outside the granted state, ihit, dhit, iload and dload are 0.
- wait_cnt: clears on entry to IACC/DACC and increments each cycle the FSM stays there without ram_ready.
- Timeout: when wait_cnt==TIMEOUT-1 and ram_ready=0, assert timeout=1 that cycle, drop ram strobes next cycle, return to IDLE with no hit. The requester retries.
- Latency: at least 1 arbitration cycle in IDLE plus RAM latency. The zero-wait RAM case gives 2 cycles per access. Back-to-back accesses always pass through IDLE.
- dstreak: 0..MAX_DSTREAK, saturating. It is only evaluated in IDLE.

Test Plan:
- Reset with all inputs 0 -> all outputs 0 and state IDLE. Assert nRST=0 during DACC with ramWEN=1 -> ramWEN falls in the same cycle.
- iREN=1, iaddr=0x40, ram_ready tied 1 -> ramREN=1 and ramaddr=0x40 in cycle 2. ihit pulses in cycle 2 with iload=ramload=0x8C220004. ihit repeats every 2 cycles.
- iREN=1 and dREN=1 (daddr=0x100) together, zero-wait RAM -> the data grant goes first. dhit and dload=ramload occur before any ihit.
- iREN and dWEN held high continuously, MAX_DSTREAK=4 -> 4 data grants, then 1 instruction grant, then the pattern repeats. dstreak returns to 0 after the ihit.
- DACC write with ram_ready held 0, TIMEOUT=16 -> timeout pulses on the 16th cycle in DACC. ramWEN drops next cycle and dhit never asserts.
- In IACC, deassert iREN in the same cycle ram_ready=1 -> no ihit. The FSM returns to IDLE and a pending dREN is granted next.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: single-port RAM arbiter between the instruction-fetch and
// data-memory ports of the pipelined MIPS datapath. Data requests win ties
// (the MEM-stage instruction is older), a streak limit keeps fetch from
// starving, and a per-access timeout aborts accesses the RAM never completes.
module ram_arbiter #(
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        ihit,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dhit,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ram_ready,
  output logic        timeout
);

  localparam int SW = $clog2(MAX_DSTREAK + 1);
  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2
  } state_t;

  state_t        state, next_state;
  logic [SW-1:0] dstreak, next_dstreak;
  logic [WW-1:0] wait_cnt, next_wait_cnt;

  // State register and counters; async reset drops the RAM strobes at once.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      dstreak  <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= next_state;
      dstreak  <= next_dstreak;
      wait_cnt <= next_wait_cnt;
    end
  end

  // Arbitration, access sequencing and the combinational RAM/requester outputs.
  always_comb begin
    next_state    = state;
    next_dstreak  = dstreak;
    next_wait_cnt = wait_cnt;
    ihit          = 1'b0;
    iload         = 32'd0;
    dhit          = 1'b0;
    dload         = 32'd0;
    ramREN        = 1'b0;
    ramWEN        = 1'b0;
    ramaddr       = 32'd0;
    ramstore      = 32'd0;
    timeout       = 1'b0;
    case (state)
      IDLE: begin
        next_wait_cnt = '0;
        if ((dREN || dWEN) && (!iREN || (dstreak < STREAK_MAX))) begin
          next_state = DACC;
          if (iREN) begin
            // Fetch is waiting behind this grant: count it toward the limit.
            next_dstreak = (dstreak == STREAK_MAX) ? dstreak : dstreak + SW'(1);
          end else begin
            next_dstreak = '0;
          end
        end else if (iREN) begin
          next_state   = IACC;
          next_dstreak = '0;
        end else begin
          next_state = IDLE;
        end
      end
      IACC: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        if (!iREN) begin
          // Withdrawn request (e.g. pipeline flush) beats a late ram_ready.
          next_state = IDLE;
        end else if (ram_ready) begin
          ihit       = 1'b1;
          iload      = ramload;
          next_state = IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout    = 1'b1;
          next_state = IDLE;
        end else begin
          next_wait_cnt = wait_cnt + WW'(1);
        end
      end
      DACC: begin
        ramaddr = daddr;
        if (dWEN) begin
          ramWEN   = 1'b1;
          ramstore = dstore;
        end else if (dREN) begin
          ramREN = 1'b1;
        end else begin
          ramREN = 1'b0;
        end
        if (!(dREN || dWEN)) begin
          next_state = IDLE;
        end else if (ram_ready) begin
          dhit       = 1'b1;
          dload      = dWEN ? 32'd0 : ramload;
          next_state = IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout    = 1'b1;
          next_state = IDLE;
        end else begin
          next_wait_cnt = wait_cnt + WW'(1);
        end
      end
      default: begin
        next_state    = IDLE;
        next_dstreak  = '0;
        next_wait_cnt = '0;
      end
    endcase
  end

endmodule
